// File: rtl/wfg_wb_init_seq_if.sv
// wfg_wb_init_seq_if: Wishbone classic bus between the init sequencer (master) and wfg_top (slave)
interface wfg_wb_init_seq_if #(parameter int BUSW = 32);
  logic [BUSW-1:0] wbm_adr_o;
  logic [BUSW-1:0] wbm_datwr_o;
  logic [BUSW-1:0] wbm_datrd_i;
  logic            wbm_we_o;
  logic            wbm_stb_o;
  logic            wbm_cyc_o;
  logic            wbm_ack_i;
  modport master (
    output wbm_adr_o, wbm_datwr_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
    input  wbm_datrd_i, wbm_ack_i
  );
  modport slave (
    input  wbm_adr_o, wbm_datwr_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
    output wbm_datrd_i, wbm_ack_i
  );
endinterface

// File: rtl/wfg_wb_init_seq.sv
// wfg_wb_init_seq: replays a fixed register-write table over Wishbone, optional readback check and ack timeout
module wfg_wb_init_seq #(
  parameter int                         BUSW       = 32,
  parameter int                         NUM_WRITES = 4,
  parameter logic [NUM_WRITES*BUSW-1:0] INIT_ADR   = '0,
  parameter logic [NUM_WRITES*BUSW-1:0] INIT_DAT   = '0,
  parameter bit                         VERIFY     = 1,
  parameter int                         TIMEOUT    = 255,
  parameter bit                         AUTO_START = 1
) (
  input  logic                     io_wbs_clk,
  input  logic                     io_wbs_rst,
  input  logic                     start_i,
  wfg_wb_init_seq_if.master        wbm,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [7:0]               err_idx_o
);
  localparam int IW = $clog2(NUM_WRITES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_RD, S_FIN, S_ERR} state_t;
  state_t          r_state, w_nxt;
  logic [IW-1:0]   r_idx, w_idx;
  logic [TW-1:0]   r_cnt;
  logic            r_prev, r_pend, r_was_wr, r_stb, r_we;
  logic [BUSW-1:0] r_adr, r_datwr;
  logic            w_ack, w_tmo, w_go, w_last, w_match, w_xfer;
  logic [BUSW-1:0] w_adr_tab [2**IW];
  logic [BUSW-1:0] w_dat_tab [2**IW];
  // table padded to a power of two so any index value selects a defined entry
  for (genvar i = 0; i < 2**IW; i++) begin : g_tab
    if (i < NUM_WRITES) begin : g_v
      assign w_adr_tab[i] = INIT_ADR[i*BUSW +: BUSW];
      assign w_dat_tab[i] = INIT_DAT[i*BUSW +: BUSW];
    end else begin : g_z
      assign w_adr_tab[i] = '0;
      assign w_dat_tab[i] = '0;
    end
  end
  assign w_ack   = r_stb & wbm.wbm_ack_i;
  assign w_tmo   = r_cnt == TW'(TIMEOUT - 1);
  assign w_go    = (r_state == S_IDLE) & r_pend;
  assign w_last  = r_idx == IW'(NUM_WRITES - 1);
  assign w_match = wbm.wbm_datrd_i == w_dat_tab[r_idx];
  assign w_xfer  = (w_nxt == S_WR) || (w_nxt == S_RD);
  always_comb begin
    w_nxt = r_state;
    w_idx = r_idx;
    case (r_state)
      S_IDLE: if (r_pend) begin
        w_nxt = S_WR;
        w_idx = '0;
      end
      S_WR:   w_nxt = w_ack ? S_GAP : w_tmo ? S_ERR : S_WR;
      S_RD:   w_nxt = w_ack ? (w_match ? S_GAP : S_ERR) : w_tmo ? S_ERR : S_RD;
      S_GAP:  if (VERIFY && r_was_wr) w_nxt = S_RD;
              else if (w_last) w_nxt = S_FIN;
              else begin
                w_nxt = S_WR;
                w_idx = r_idx + 1'b1;
              end
      default: w_nxt = S_IDLE;
    endcase
  end
  // bus outputs are registered from the next state so they change with the state
  always_ff @(posedge io_wbs_clk or posedge io_wbs_rst)
    if (io_wbs_rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_prev    <= 1'b0;
      r_pend    <= AUTO_START;
      r_was_wr  <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_datwr   <= '0;
      done_o    <= 1'b0;
      error_o   <= 1'b0;
      err_idx_o <= '0;
    end else begin
      r_state   <= w_nxt;
      r_idx     <= w_idx;
      r_cnt     <= r_stb ? r_cnt + 1'b1 : '0;
      r_prev    <= start_i;
      r_pend    <= (r_state == S_IDLE) && (w_nxt == S_IDLE) && start_i && !r_prev;
      r_was_wr  <= r_state == S_WR;
      r_stb     <= w_xfer;
      r_we      <= w_nxt == S_WR;
      r_adr     <= w_xfer ? w_adr_tab[w_idx] : '0;
      r_datwr   <= (w_nxt == S_WR) ? w_dat_tab[w_idx] : '0;
      done_o    <= w_go ? 1'b0 : (r_state == S_FIN) | done_o;
      error_o   <= w_go ? 1'b0 : (r_state == S_ERR) | error_o;
      err_idx_o <= w_go ? '0 : (r_state == S_ERR) ? 8'(r_idx) : err_idx_o;
    end
  assign busy_o          = r_state != S_IDLE;
  assign wbm.wbm_stb_o   = r_stb;
  assign wbm.wbm_cyc_o   = r_stb;
  assign wbm.wbm_we_o    = r_we;
  assign wbm.wbm_adr_o   = r_adr;
  assign wbm.wbm_datwr_o = r_datwr;
endmodule

// File: tb/tb_wfg_wb_init_seq.sv
// tb_wfg_wb_init_seq: scoreboard bench; a negedge slave model answers the bus, expected transfers are queued per run
module tb_wfg_wb_init_seq;
  typedef struct packed {logic we; logic [31:0] adr; logic [31:0] dat;} xfer_t;
  logic       clk = 0, rst = 1, start = 0;
  logic       busy, done, error;
  logic [7:0] err_idx;
  int         checks = 0, failures = 0;
  xfer_t      q[$];
  int         lat = 1, sn = 0, n_xfer = 0, stb_len = 0, gap_n = 0;
  bit         no_ack = 0, corrupt = 0, gap_chk = 0, stb_q = 0;
  logic [31:0] mem [2];
  logic [31:0] adr_q, dat_q;
  logic        we_q;
  wfg_wb_init_seq_if #(.BUSW(32)) wb();
  wfg_wb_init_seq #(
    .BUSW(32), .NUM_WRITES(2),
    .INIT_ADR({32'h4, 32'h0}), .INIT_DAT({32'h1, 32'h3}),
    .VERIFY(1), .TIMEOUT(8), .AUTO_START(1)
  ) dut (
    .io_wbs_clk(clk), .io_wbs_rst(rst), .start_i(start), .wbm(wb.master),
    .busy_o(busy), .done_o(done), .error_o(error), .err_idx_o(err_idx)
  );
  always #5 clk = ~clk;
  initial begin
    xfer_t e;
    wb.wbm_ack_i = 0;
    wb.wbm_datrd_i = 0;
    forever @(negedge clk) begin
      if (wb.wbm_stb_o && !no_ack) begin
        sn++;
        if (sn > lat) begin
          wb.wbm_ack_i = 1;
          if (wb.wbm_we_o) mem[wb.wbm_adr_o[2]] = wb.wbm_datwr_o;
          else wb.wbm_datrd_i = mem[wb.wbm_adr_o[2]] ^ ((corrupt && wb.wbm_adr_o[2]) ? 32'h3 : 32'h0);
        end
      end else begin
        sn = 0;
        wb.wbm_ack_i = 0;
        wb.wbm_datrd_i = 0;
      end
      if (wb.wbm_stb_o) begin
        if (!stb_q) begin
          stb_len = 0;
          if (gap_chk) begin
            checks++;
            if (gap_n != 1) begin failures++; $display("FAIL gap: got %0d idle cycles, want 1", gap_n); end
          end
        end else begin
          checks++;
          if ({wb.wbm_we_o, wb.wbm_adr_o, wb.wbm_datwr_o} !== {we_q, adr_q, dat_q}) begin
            failures++; $display("FAIL hold: bus changed while stb high adr=%h dat=%h", wb.wbm_adr_o, wb.wbm_datwr_o);
          end
        end
        stb_len++;
        if (wb.wbm_ack_i) begin
          checks++;
          if (q.size() == 0) begin
            failures++; $display("FAIL xfer: unexpected we=%b adr=%h dat=%h", wb.wbm_we_o, wb.wbm_adr_o, wb.wbm_datwr_o);
          end else begin
            e = q.pop_front();
            if ({wb.wbm_we_o, wb.wbm_adr_o, wb.wbm_datwr_o} !== e) begin
              failures++; $display("FAIL xfer: got we=%b adr=%h dat=%h want we=%b adr=%h dat=%h",
                wb.wbm_we_o, wb.wbm_adr_o, wb.wbm_datwr_o, e.we, e.adr, e.dat);
            end
          end
          n_xfer++;
          gap_chk = 1;
          gap_n = 0;
        end
      end else gap_n++;
      stb_q = wb.wbm_stb_o;
      we_q = wb.wbm_we_o;
      adr_q = wb.wbm_adr_o;
      dat_q = wb.wbm_datwr_o;
    end
  end
  task automatic push_run();
    q.push_back({1'b1, 32'h0, 32'h3});
    q.push_back({1'b0, 32'h0, 32'h0});
    q.push_back({1'b1, 32'h4, 32'h1});
    q.push_back({1'b0, 32'h4, 32'h0});
  endtask
  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin @(negedge clk); n++; end
    checks++;
    if (busy) begin failures++; $display("FAIL idle_wait: busy=%b after %0d cycles, want 0", busy, max); end
  endtask
  task automatic kick();
    int n = 0;
    gap_chk = 0;
    n_xfer = 0;
    @(negedge clk) start = 1;
    while (!busy && n < 6) begin @(negedge clk); n++; end
    start = 0;
    checks++;
    if ({busy, done, error, err_idx} !== {1'b1, 10'd0}) begin
      failures++; $display("FAIL kick: busy=%b done=%b error=%b err_idx=%0d want 1 0 0 0", busy, done, error, err_idx);
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, busy, done, error, err_idx, wb.wbm_adr_o, wb.wbm_datwr_o} !== '0) begin
      failures++; $display("FAIL reset: cyc=%b stb=%b we=%b busy=%b done=%b error=%b want all 0",
        wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, busy, done, error);
    end
    push_run();
    gap_chk = 0;
    n_xfer = 0;
    rst = 0;
    #1;
    checks++;
    if (wb.wbm_stb_o !== 1'b0) begin failures++; $display("FAIL auto_first: stb=%b in 1st cycle, want 0", wb.wbm_stb_o); end
    @(negedge clk);
    checks++;
    if ({wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, wb.wbm_adr_o, wb.wbm_datwr_o} !== {3'b111, 32'h0, 32'h3}) begin
      failures++; $display("FAIL auto_second: cyc=%b stb=%b we=%b adr=%h dat=%h want 1 1 1 0 3",
        wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, wb.wbm_adr_o, wb.wbm_datwr_o);
    end
  endtask
  task automatic test_sequence();
    wait_idle(200);
    checks++;
    if ({done, error, n_xfer, q.size()} !== {2'b10, 32'd4, 32'd0}) begin
      failures++; $display("FAIL sequence: done=%b error=%b xfers=%0d left=%0d want 1 0 4 0", done, error, n_xfer, q.size());
    end
    checks++;
    if ({wb.wbm_cyc_o, wb.wbm_adr_o, wb.wbm_datwr_o} !== '0) begin
      failures++; $display("FAIL idle_bus: cyc=%b adr=%h dat=%h want 0", wb.wbm_cyc_o, wb.wbm_adr_o, wb.wbm_datwr_o);
    end
  endtask
  task automatic test_start_ignored();
    push_run();
    kick();
    repeat (3) begin
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
    end
    wait_idle(200);
    repeat (10) @(negedge clk);
    checks++;
    if ({busy, done, error, n_xfer, q.size()} !== {3'b010, 32'd4, 32'd0}) begin
      failures++; $display("FAIL start_ignored: busy=%b done=%b error=%b xfers=%0d left=%0d want 0 1 0 4 0",
        busy, done, error, n_xfer, q.size());
    end
  endtask
  task automatic test_back_to_back();
    push_run();
    kick();
    wait_idle(200);
    checks++;
    if ({done, error, n_xfer, q.size()} !== {2'b10, 32'd4, 32'd0}) begin
      failures++; $display("FAIL replay: done=%b error=%b xfers=%0d left=%0d want 1 0 4 0", done, error, n_xfer, q.size());
    end
  endtask
  task automatic test_readback_error();
    corrupt = 1;
    push_run();
    kick();
    wait_idle(200);
    corrupt = 0;
    repeat (10) @(negedge clk);
    checks++;
    if ({busy, done, error, err_idx, n_xfer, q.size()} !== {3'b001, 8'd1, 32'd4, 32'd0}) begin
      failures++; $display("FAIL readback: busy=%b done=%b error=%b err_idx=%0d xfers=%0d left=%0d want 0 0 1 1 4 0",
        busy, done, error, err_idx, n_xfer, q.size());
    end
  endtask
  task automatic test_timeout();
    no_ack = 1;
    kick();
    wait_idle(50);
    no_ack = 0;
    checks++;
    if (stb_len != 8) begin failures++; $display("FAIL timeout_len: stb high %0d cycles, want 8", stb_len); end
    checks++;
    if ({wb.wbm_cyc_o, wb.wbm_stb_o, busy, done, error, err_idx, n_xfer} !== {5'b00001, 8'd0, 32'd0}) begin
      failures++; $display("FAIL timeout: cyc=%b stb=%b busy=%b done=%b error=%b err_idx=%0d xfers=%0d want 0 0 0 0 1 0 0",
        wb.wbm_cyc_o, wb.wbm_stb_o, busy, done, error, err_idx, n_xfer);
    end
  endtask
  task automatic test_ack_at_timeout();
    lat = 7;
    push_run();
    kick();
    wait_idle(300);
    checks++;
    if ({done, error, n_xfer, q.size()} !== {2'b10, 32'd4, 32'd0}) begin
      failures++; $display("FAIL ack_at_limit: done=%b error=%b xfers=%0d left=%0d want 1 0 4 0", done, error, n_xfer, q.size());
    end
    lat = 8;
    kick();
    wait_idle(300);
    lat = 1;
    checks++;
    if ({done, error, err_idx, stb_len, n_xfer} !== {2'b01, 8'd0, 32'd8, 32'd0}) begin
      failures++; $display("FAIL ack_late: done=%b error=%b err_idx=%0d stb_len=%0d xfers=%0d want 0 1 0 8 0",
        done, error, err_idx, stb_len, n_xfer);
    end
  endtask
  task automatic test_reset_midrun();
    int n = 0;
    lat = 3;
    kick();
    #2 rst = 1;
    #1;
    checks++;
    if ({wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, busy} !== 4'b0) begin
      failures++; $display("FAIL async_rst: cyc=%b stb=%b we=%b busy=%b want 0", wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, busy);
    end
    q.delete();
    push_run();
    lat = 1;
    @(negedge clk);
    gap_chk = 0;
    n_xfer = 0;
    rst = 0;
    while (!busy && n < 6) begin @(negedge clk); n++; end
    wait_idle(200);
    checks++;
    if ({done, error, n_xfer, q.size()} !== {2'b10, 32'd4, 32'd0}) begin
      failures++; $display("FAIL restart: done=%b error=%b xfers=%0d left=%0d want 1 0 4 0", done, error, n_xfer, q.size());
    end
  endtask
  initial begin
    test_reset();
    test_sequence();
    test_start_ignored();
    test_back_to_back();
    test_readback_error();
    test_timeout();
    test_ack_at_timeout();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
